// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and constants for the pipeline stall/flush sequencer.
//   state_t  : sequencer states (RUN, MEM_WAIT, ERROR)
//   REG_ZERO : architectural $zero register index; never a real hazard source
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// load_use_detect: combinational load-use hazard compare.
//   ID_EX_MemRead, ID_EX_Rt : load currently in EX and its destination
//   IF_ID_Rs, IF_ID_Rt      : source registers of the instruction in ID
//   Load_Use                : 1 when the ID instruction needs the loaded value
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_Rt,
    input  logic [4:0] IF_ID_Rs,
    input  logic [4:0] IF_ID_Rt,
    output logic       Load_Use
);

    // A load into $zero produces nothing to wait for.
    assign Load_Use = ID_EX_MemRead && (ID_EX_Rt != REG_ZERO) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
//   Inputs : hazard info from ID/EX, branch/memory info from EX/MEM, DMem_Ack
//   Outputs: PC and pipeline-register write enables / flushes, PCSrc,
//            DMem_Req, sticky Err, StallCount, Dbg_State (current FSM state)
//
// Data memory handshake: DMem_Req is high for every cycle an access is
// outstanding (from the cycle the memop reaches MEM until the cycle DMem_Ack
// is seen). The access completes in the first cycle where DMem_Req and
// DMem_Ack are both high; DMem_Ack while DMem_Req is low is ignored.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rt,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             EX_MEM_Branch,
    input  logic             EX_MEM_Zero,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic             DMem_Ack,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic             EX_MEM_Flush,
    output logic             MEM_WB_Flush,
    output logic             DMem_Req,
    output logic             Err,
    output logic [CNT_W-1:0] StallCount,
    output state_t           Dbg_State
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q, err_d;
    logic               cnt_inc;
    logic               adv;      // pipeline moves this cycle (taken/loaduse are evaluated)
    logic               req;
    logic               memop, taken, load_use;

    assign memop = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign taken = EX_MEM_Branch & EX_MEM_Zero;

    load_use_detect u_load_use (
        .ID_EX_MemRead (ID_EX_MemRead),
        .ID_EX_Rt      (ID_EX_Rt),
        .IF_ID_Rs      (IF_ID_Rs),
        .IF_ID_Rt      (IF_ID_Rt),
        .Load_Use      (load_use)
    );

    // Next-state, wait counter and stall accounting.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        req     = 1'b0;
        adv     = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            RUN: begin
                if (memop) begin
                    req = 1'b1;
                    if (DMem_Ack) begin
                        adv = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                        wait_d  = WAIT_W'(1);
                        cnt_inc = 1'b1;
                    end
                end else begin
                    adv = 1'b1;
                end
                // Load-use bubble is a counted stall; a taken branch squashes it.
                if (adv && !taken && load_use) begin
                    cnt_inc = 1'b1;
                end
            end
            MEM_WAIT: begin
                req = 1'b1;
                if (DMem_Ack) begin
                    // Completion cycle: advances like RUN but is not counted.
                    adv     = 1'b1;
                    state_d = RUN;
                    wait_d  = '0;
                end else begin
                    cnt_inc = 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            ERROR: begin
                adv = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Mealy output decode; reset forces everything frozen and flushed.
    always_comb begin
        PCWrite      = adv & (taken | ~load_use);
        PCSrc        = adv & taken;
        IF_ID_Write  = adv & (taken | ~load_use);
        IF_ID_Flush  = adv & taken;
        ID_EX_Write  = adv;
        ID_EX_Flush  = adv & (taken | load_use);
        EX_MEM_Write = adv;
        EX_MEM_Flush = adv & taken;
        MEM_WB_Flush = ~adv;
        DMem_Req     = req;
        if (!Rst_n) begin
            PCWrite      = 1'b0;
            PCSrc        = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Write  = 1'b0;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Write = 1'b0;
            EX_MEM_Flush = 1'b1;
            MEM_WB_Flush = 1'b1;
            DMem_Req     = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign Err        = err_q;
    assign StallCount = cnt_q;
    assign Dbg_State  = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed bench for pipeline_ctrl with a cycle-level
// reference model and hand-computed checkpoints.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;
    localparam int W           = 11 + 2 + CNT_W;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    logic             ID_EX_MemRead = 1'b0;
    logic [4:0]       ID_EX_Rt = '0;
    logic [4:0]       IF_ID_Rs = '0;
    logic [4:0]       IF_ID_Rt = '0;
    logic             EX_MEM_Branch = 1'b0;
    logic             EX_MEM_Zero = 1'b0;
    logic             EX_MEM_MemRead = 1'b0;
    logic             EX_MEM_MemWrite = 1'b0;
    logic             DMem_Ack = 1'b0;
    logic             PCWrite, PCSrc, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
    logic             EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush, DMem_Req, Err;
    logic [CNT_W-1:0] StallCount;
    state_t           Dbg_State;

    pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
        .EX_MEM_Branch(EX_MEM_Branch), .EX_MEM_Zero(EX_MEM_Zero),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .DMem_Ack(DMem_Ack),
        .PCWrite(PCWrite), .PCSrc(PCSrc),
        .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush),
        .EX_MEM_Write(EX_MEM_Write), .EX_MEM_Flush(EX_MEM_Flush),
        .MEM_WB_Flush(MEM_WB_Flush), .DMem_Req(DMem_Req), .Err(Err),
        .StallCount(StallCount), .Dbg_State(Dbg_State)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // Tracks: an access outstanding, how many stalled cycles it has cost, a
    // latched timeout, and the total stall count.
    logic             m_wait, m_err;
    int               m_cnt;
    logic [CNT_W-1:0] m_sc;

    function automatic logic f_memop();
        return EX_MEM_MemRead | EX_MEM_MemWrite;
    endfunction
    function automatic logic f_taken();
        return EX_MEM_Branch & EX_MEM_Zero;
    endfunction
    function automatic logic f_lu();
        return ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
               (ID_EX_Rt == IF_ID_Rs || ID_EX_Rt == IF_ID_Rt);
    endfunction

    // Expected {PCWrite,PCSrc,IF_ID_Write,IF_ID_Flush,ID_EX_Write,ID_EX_Flush,
    //           EX_MEM_Write,EX_MEM_Flush,MEM_WB_Flush,DMem_Req,Err}, state, count.
    function automatic logic [W-1:0] predict();
        logic [10:0] c;
        logic [1:0]  st;
        logic        moving, rq;
        st = m_err ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
        if (!Rst_n) begin
            c = 11'b000_1010_1100;
        end else begin
            moving = !m_err && (DMem_Ack || (!m_wait && !f_memop()));
            rq     = !m_err && (m_wait || f_memop());
            if (!moving)        c = {8'b0000_0000, 1'b1, rq, m_err};
            else if (f_taken()) c = {8'b1111_1111, 1'b0, rq, m_err};
            else if (f_lu())    c = {8'b0000_1110, 1'b0, rq, m_err};
            else                c = {8'b1010_1010, 1'b0, rq, m_err};
        end
        return {c, st, m_sc};
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_wait <= 1'b0;
            m_err  <= 1'b0;
            m_cnt  <= 0;
            m_sc   <= '0;
        end else if (!m_err) begin
            if (m_wait) begin
                if (DMem_Ack) begin
                    m_wait <= 1'b0;
                end else begin
                    m_sc <= m_sc + 1;
                    if (m_cnt + 1 == MEM_TIMEOUT) m_err <= 1'b1;
                    else                          m_cnt <= m_cnt + 1;
                end
            end else if (f_memop() && !DMem_Ack) begin
                m_wait <= 1'b1;
                m_cnt  <= 1;
                m_sc   <= m_sc + 1;
            end else if (!f_taken() && f_lu()) begin
                m_sc <= m_sc + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] dut_vec;
    assign dut_vec = {PCWrite, PCSrc, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
                      EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush, DMem_Req, Err,
                      Dbg_State, StallCount};

    always @(negedge Clk) exp_q.push_back(predict());

    always @(negedge Clk) begin
        logic [W-1:0] e;
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL cycle_check: no expectation queued at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (dut_vec !== e) begin
                n_fail++;
                $display("FAIL cycle_check @%0t: got ctl=%b st=%0d cnt=%0d, expected ctl=%b st=%0d cnt=%0d",
                         $time, dut_vec[W-1 -: 11], dut_vec[CNT_W +: 2], dut_vec[CNT_W-1:0],
                         e[W-1 -: 11], e[CNT_W +: 2], e[CNT_W-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic z,
                         input logic emr, input logic emw, input logic ack);
        ID_EX_MemRead   = mr;
        ID_EX_Rt        = ex_rt;
        IF_ID_Rs        = rs;
        IF_ID_Rt        = rt;
        EX_MEM_Branch   = br;
        EX_MEM_Zero     = z;
        EX_MEM_MemRead  = emr;
        EX_MEM_MemWrite = emw;
        DMem_Ack        = ack;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Hand-computed checkpoint.
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        idle();
        tick();
        #2;
        lit("rst_pcwrite", 32'(PCWrite), 0);
        lit("rst_if_id_flush", 32'(IF_ID_Flush), 1);
        lit("rst_mem_wb_flush", 32'(MEM_WB_Flush), 1);
        lit("rst_req", 32'(DMem_Req), 0);
        tick();
        Rst_n = 1'b1;

        // Load-use: one counted bubble.
        drive(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        lit("lu_pcwrite", 32'(PCWrite), 0);
        lit("lu_if_id_write", 32'(IF_ID_Write), 0);
        lit("lu_id_ex_flush", 32'(ID_EX_Flush), 1);
        tick();
        idle();
        #2;
        lit("lu_count", StallCount, 1);
        lit("lu_released", 32'(PCWrite), 1);
        // Load into $zero is not a hazard.
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        lit("lu_zero_pcwrite", 32'(PCWrite), 1);
        tick();
        idle();
        #2;
        lit("lu_zero_count", StallCount, 1);

        // Taken branch beats load-use.
        drive(1'b1, 5'd9, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        lit("br_pcsrc", 32'(PCSrc), 1);
        lit("br_pcwrite", 32'(PCWrite), 1);
        lit("br_ex_mem_flush", 32'(EX_MEM_Flush), 1);
        tick();
        // Not taken: load-use stall only.
        drive(1'b1, 5'd9, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        lit("br_count_unchanged", StallCount, 1);
        lit("nt_pcsrc", 32'(PCSrc), 0);
        lit("nt_pcwrite", 32'(PCWrite), 0);
        tick();
        idle();
        #2;
        lit("nt_count", StallCount, 2);

        // Single-cycle memory.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        #2;
        lit("sc_req", 32'(DMem_Req), 1);
        lit("sc_ex_mem_write", 32'(EX_MEM_Write), 1);
        tick();
        idle();
        #2;
        lit("sc_state", 32'(Dbg_State), 32'(RUN));
        lit("sc_count", StallCount, 2);

        // Multi-cycle store with a pending load-use; ack on the 4th cycle.
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #2;
            lit("mc_wait_flush", 32'(MEM_WB_Flush), 1);
            lit("mc_wait_pcwrite", 32'(PCWrite), 0);
            lit("mc_wait_id_ex_flush", 32'(ID_EX_Flush), 0);
            tick();
        end
        DMem_Ack = 1'b1;
        #2;
        lit("mc_ack_mem_wb_flush", 32'(MEM_WB_Flush), 0);
        lit("mc_ack_id_ex_write", 32'(ID_EX_Write), 1);
        lit("mc_ack_lu_pcwrite", 32'(PCWrite), 0);
        lit("mc_ack_lu_flush", 32'(ID_EX_Flush), 1);
        tick();
        idle();
        #2;
        lit("mc_count", StallCount, 5);
        lit("mc_state", 32'(Dbg_State), 32'(RUN));

        // Timeout: 16 stalled cycles then sticky error.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < MEM_TIMEOUT; i++) tick();
        #2;
        lit("to_err", 32'(Err), 1);
        lit("to_count", StallCount, 21);
        lit("to_req", 32'(DMem_Req), 0);
        DMem_Ack = 1'b1;
        tick();
        tick();
        #2;
        lit("to_late_ack_err", 32'(Err), 1);
        lit("to_late_ack_count", StallCount, 21);
        lit("to_late_ack_pcwrite", 32'(PCWrite), 0);

        // Reset mid-wait.
        idle();
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        #1;
        lit("rw_req_before", 32'(DMem_Req), 1);
        #1;
        Rst_n = 1'b0;
        #1;
        lit("rw_req_dropped", 32'(DMem_Req), 0);
        lit("rw_if_id_flush", 32'(IF_ID_Flush), 1);
        lit("rw_ex_mem_flush", 32'(EX_MEM_Flush), 1);
        idle();
        tick();
        Rst_n = 1'b1;
        #2;
        lit("rw_state", 32'(Dbg_State), 32'(RUN));
        lit("rw_count", StallCount, 0);
        lit("rw_err", 32'(Err), 0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the write enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards and resolves taken branches (branch in MEM stage).
- Runs a req/ack handshake with a multi-cycle data memory and freezes the pipeline while an access is outstanding.
- Keeps a stall-cycle performance counter and a sticky memory-timeout error.

Parameters:
MEM_TIMEOUT, 16, wait cycles in MEM_WAIT without DMem_Ack before ERROR (minimum 2)
CNT_W, 32, StallCount width

Ports:
Clk  in  1  clock, all state updates on posedge
Rst_n  in  1  asynchronous active-low reset
ID_EX_MemRead  in  1  load in EX stage
ID_EX_Rt  in  5  destination of load in EX
IF_ID_Rs  in  5  source register of instruction in ID
IF_ID_Rt  in  5  source register of instruction in ID
EX_MEM_Branch  in  1  branch in MEM stage
EX_MEM_Zero  in  1  ALU zero of branch in MEM
EX_MEM_MemRead  in  1  load in MEM stage
EX_MEM_MemWrite  in  1  store in MEM stage
DMem_Ack  in  1  data memory completes access this cycle
PCWrite  out  1  PC load enable
PCSrc  out  1  1 = take branch target
IF_ID_Write  out  1  IF/ID load enable
IF_ID_Flush  out  1  zero IF/ID
ID_EX_Write  out  1  ID/EX load enable
ID_EX_Flush  out  1  load bubble into ID/EX control fields
EX_MEM_Write  out  1  EX/MEM load enable
EX_MEM_Flush  out  1  load bubble into EX/MEM control fields
MEM_WB_Flush  out  1  load bubble into MEM/WB
DMem_Req  out  1  data memory request
Err  out  1  sticky memory-timeout flag
StallCount  out  CNT_W  stall cycles since reset

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- Outputs are Mealy (combinational from state and inputs). StallCount, the wait counter and Err are registered.
- While Rst_n=0:
  - State=RUN, wait counter=0, StallCount=0, Err=0.
  - All *_Write=0, PCSrc=0, DMem_Req=0, all *_Flush=1.
- memop = EX_MEM_MemRead | EX_MEM_MemWrite.
- loaduse = ID_EX_MemRead & ID_EX_Rt!=0 & (ID_EX_Rt==IF_ID_Rs | ID_EX_Rt==IF_ID_Rt).
- taken = EX_MEM_Branch & EX_MEM_Zero.
- RUN defaults: all *_Write=1, all *_Flush=0, PCSrc=0. Priority order is memop, then taken, then loaduse.
  - memop:
    - DMem_Req=1.
    - If DMem_Ack is also 1: no stall, normal advance, and taken/loaduse are still evaluated this cycle.
    - If DMem_Ack=0: all *_Write=0, MEM_WB_Flush=1, go MEM_WAIT, wait counter<=1, StallCount+1.
  - taken (no stall): PCSrc=1, PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Flush=1. A simultaneous loaduse is ignored, with no stall and no count.
  - loaduse: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, StallCount+1. Exactly one bubble per hazard, because the next cycle the load has left EX.
- MEM_WAIT: DMem_Req=1 and the pipeline stays frozen (all *_Write=0, MEM_WB_Flush=1). taken and loaduse are ignored.
  - DMem_Ack=1: this cycle behaves as a RUN cycle with the memop already satisfied (writes=1, MEM_WB_Flush=0, taken/loaduse evaluated). Go RUN, wait counter<=0. No StallCount increment this cycle.
  - DMem_Ack=0 and wait counter==MEM_TIMEOUT-1: go ERROR, Err<=1, StallCount+1.
  - Otherwise: wait counter+1, StallCount+1.
- ERROR: all *_Write=0, DMem_Req=0, MEM_WB_Flush=1, Err=1, StallCount frozen. The only exit is Rst_n.
- DMem_Ack outside a request is ignored.
- StallCount wraps modulo 2^CNT_W.
- Asserting Rst_n mid-wait drops DMem_Req immediately (asynchronous) and restarts in RUN.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT, ERROR}
  - REG_ZERO = 5'd0
- One sub-module, load_use_detect: pure combinational loaduse compare, reused by a future forwarding unit.
- The FSM, counters and output decode stay in pipeline_ctrl. Target size is about 150–250 lines.

Test Plan:
1. Load-use: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 for one cycle -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly 1 cycle, StallCount 0->1. Repeat with Rt=0 -> no stall.
2. Taken branch plus load-use: EX_MEM_Branch=1, EX_MEM_Zero=1, loaduse=1 -> PCSrc=1, IF_ID/ID_EX/EX_MEM_Flush=1, PCWrite=1, StallCount unchanged. With Zero=0 -> load-use stall only.
3. Single-cycle memory: EX_MEM_MemRead=1, DMem_Ack=1 the same cycle -> DMem_Req=1, all writes=1, state stays RUN, StallCount unchanged.
4. Multi-cycle memory: EX_MEM_MemWrite=1, DMem_Ack at the 4th cycle of the request -> writes=0 and MEM_WB_Flush=1 for 3 cycles, advance on cycle 4, StallCount=3. A loaduse present during the wait is not acted on until the ack cycle.
5. Timeout: memop held, no ack, MEM_TIMEOUT=16 -> Err=1 after 16 stalled cycles, StallCount=16, DMem_Req=0 and frozen thereafter. A later DMem_Ack has no effect.
6. Reset mid-wait: deassert Rst_n asynchronously in cycle 2 of MEM_WAIT -> DMem_Req=0 and all *_Flush=1 immediately. After release: RUN, StallCount=0, Err=0.
